// File: rtl/neural_soc_from_sw_port.sv
`default_nettype none
// ============================================================================
// neural_soc_from_sw_port : Avalon-MM write port feeding a FIFO to the fabric
// Revision 1.0
// ============================================================================
module neural_soc_from_sw_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   readdata_q, readdata_d;

  logic        w_wr, w_push_req, w_push_acc, w_push_rej, w_pop;
  logic        w_flush, w_ovf_clr, w_full, w_empty;
  logic [31:0] w_cnt_ext, w_status;

  always_comb begin
    w_wr       = chipselect & ~write_n;
    w_push_req = w_wr & (address == 2'd0);
    w_flush    = w_wr & (address == 2'd2) & writedata[0];
    w_ovf_clr  = w_wr & (address == 2'd2) & writedata[1];
    w_full     = (count_q == c_FULL_CNT);
    w_empty    = (count_q == '0);
    w_pop      = ~w_empty & out_ready;
    // Acceptance is judged on the pre-edge count, so a pop never frees room for a same-cycle push.
    w_push_acc = w_push_req & ~w_full;
    w_push_rej = w_push_req & w_full;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q;

    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push_acc) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        shadow_d = writedata;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push_acc, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    if (w_push_rej) begin
      ovf_d = 1'b1;
    end else if (w_ovf_clr) begin
      ovf_d = 1'b0;
    end

    w_cnt_ext = 32'(count_q);
    w_status  = {16'h0000, w_cnt_ext[7:0], 5'b00000, ovf_q, w_full, w_empty};

    case (address)
      2'd0:    readdata_d = shadow_q;
      2'd1:    readdata_d = w_status;
      default: readdata_d = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      shadow_q   <= 32'h0000_0000;
      readdata_q <= 32'h0000_0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      shadow_q   <= shadow_d;
      readdata_q <= readdata_d;
    end
  end

  // Storage carries no reset; out_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      mem_q[wr_ptr_q] <= writedata;
    end
  end

  assign readdata  = readdata_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_neural_soc_from_sw_port.sv
`default_nettype none
// ============================================================================
// tb_neural_soc_from_sw_port : randomized and directed bench with queue model
// Revision 1.0
// ============================================================================
module tb_neural_soc_from_sw_port;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_model[$];
  logic        ovf_m = 1'b0;
  logic [31:0] shadow_m = 32'h0;
  logic [31:0] got[$];

  neural_soc_from_sw_port #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [7:0] c;
    c = 8'(q_model.size());
    case (a)
      2'd0:    return shadow_m;
      2'd1:    return {16'h0, c, 5'h0, ovf_m, q_model.size() == DEPTH, q_model.size() == 0};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: apply inputs, advance the model by the register-map rules, compare.
  task automatic cycle(input logic cs, input logic wn, input logic [1:0] a,
                       input logic [31:0] wd, input logic rdy);
    logic [31:0] exp_rd;
    logic [31:0] tmp;
    int pre;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    out_ready  = rdy;
    exp_rd = model_read(a);
    if (out_valid && rdy) got.push_back(out_data);
    @(posedge clk);
    #1;
    pre = q_model.size();
    if (cs && !wn && a == 2'd2 && wd[0]) begin
      q_model.delete();
    end else begin
      if (pre != 0 && rdy) tmp = q_model.pop_front();
      if (cs && !wn && a == 2'd0) begin
        if (pre < DEPTH) begin
          q_model.push_back(wd);
          shadow_m = wd;
        end else begin
          ovf_m = 1'b1;
        end
      end
    end
    if (cs && !wn && a == 2'd2 && wd[1]) ovf_m = 1'b0;
    check("readdata", readdata, exp_rd);
    check("out_valid", {31'h0, out_valid}, {31'h0, q_model.size() != 0});
    if (q_model.size() != 0) check("out_data", out_data, q_model[0]);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic rdy);
    cycle(1'b1, 1'b0, a, d, rdy);
  endtask

  task automatic rd(input logic [1:0] a, input logic rdy);
    cycle(1'b1, 1'b1, a, 32'h0, rdy);
  endtask

  initial begin
    logic        cs, wn, rdy;
    logic [1:0]  a;
    logic [31:0] wd;

    #12;
    check("reset_readdata", readdata, 32'h0);
    check("reset_valid", {31'h0, out_valid}, 32'h0);
    reset_n = 1'b1;

    // Single word
    wr(2'd0, 32'hDEADBEEF, 1'b0);
    check("single_valid", {31'h0, out_valid}, 32'h1);
    check("single_data", out_data, 32'hDEADBEEF);
    rd(2'd1, 1'b0);
    check("single_status", readdata, 32'h0000_0100);
    rd(2'd0, 1'b0);
    check("single_shadow", readdata, 32'hDEADBEEF);
    cycle(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);

    // Fill and overflow, then drain
    got.delete();
    for (int i = 1; i <= 5; i++) wr(2'd0, 32'(i), 1'b0);
    rd(2'd1, 1'b0);
    check("fill_status", readdata, 32'h0000_0406);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    check("fill_drain_cnt", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) check("fill_drain_word", got[i], 32'(i + 1));
    check("fill_drain_valid", {31'h0, out_valid}, 32'h0);

    // Full with concurrent pop: push is rejected
    wr(2'd2, 32'h2, 1'b0);
    for (int i = 0; i < 4; i++) wr(2'd0, 32'(10 + i), 1'b0);
    wr(2'd0, 32'd9, 1'b1);
    rd(2'd1, 1'b0);
    check("fullpop_status", readdata, 32'h0000_0304);
    rd(2'd0, 1'b0);
    check("fullpop_shadow", readdata, 32'd13);

    // Flush keeps overflow, then clear it
    cycle(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    wr(2'd2, 32'h1, 1'b0);
    check("flush_valid", {31'h0, out_valid}, 32'h0);
    rd(2'd1, 1'b0);
    check("flush_status", readdata, 32'h0000_0005);
    wr(2'd2, 32'h2, 1'b0);
    rd(2'd1, 1'b0);
    check("clear_status", readdata, 32'h0000_0001);

    // Streaming with pointer wrap
    got.delete();
    for (int i = 0; i < 20; i++) wr(2'd0, 32'(100 + i), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    check("stream_cnt", 32'(got.size()), 32'd20);
    for (int i = 0; i < got.size(); i++) check("stream_word", got[i], 32'(100 + i));
    rd(2'd1, 1'b0);
    check("stream_status", readdata, 32'h0000_0001);

    // Reset mid-stream with 3 words buffered
    for (int i = 0; i < 3; i++) wr(2'd0, 32'(200 + i), 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_valid", {31'h0, out_valid}, 32'h0);
    check("midreset_readdata", readdata, 32'h0);
    chipselect = 1'b0;
    write_n    = 1'b1;
    q_model.delete();
    ovf_m    = 1'b0;
    shadow_m = 32'h0;
    #1;
    reset_n = 1'b1;
    rd(2'd1, 1'b0);
    check("midreset_status", readdata, 32'h0000_0001);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      cs  = ($urandom_range(0, 3) != 0);
      wn  = 1'($urandom % 2);
      a   = 2'($urandom % 4);
      wd  = $urandom;
      rdy = 1'($urandom % 2);
      if (a == 2'd2 && ($urandom % 4) != 0) wd[0] = 1'b0;
      cycle(cs, wn, a, wd, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
